// File: rtl/pc_pkg.sv
// Shared types and constants for the next-PC sequencer.
package pc_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [1:0] NO_CHANGE_NONE = 2'b00;
  localparam logic [1:0] NO_CHANGE_HOLD = 2'b01;

  localparam logic [PC_W-1:0] VEC_ADDR_DEFAULT = 32'h0000_0020;

  typedef enum logic [1:0] {
    S_RST       = 2'b00,
    S_RUN       = 2'b01,
    S_INT_DRAIN = 2'b10,
    S_INT_VEC   = 2'b11
  } pc_state_t;

endpackage : pc_pkg

// File: rtl/pc_drain_counter.sv
// Loadable down-counter timing the pipeline drain before an interrupt vector jump.
module pc_drain_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero_c,
  output logic         one_c
);

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero_c) begin
      count <= count - W'(1);
    end
  end

  // Flags decoded from the current count.
  always_comb begin
    zero_c = (count == W'(0));
    one_c  = (count == W'(1));
  end

endmodule : pc_drain_counter

// File: rtl/pc_sequencer.sv
// Next-PC generator and fetch-control sequencer with interrupt-entry handshake.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     DRAIN_CYCLES = 3,
  parameter logic [PC_W-1:0] VEC_ADDR     = VEC_ADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            is_32bit,
  input  logic [1:0]      hazard_hold,
  input  logic            load_use,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            ret_valid,
  input  logic [PC_W-1:0] ret_addr,
  input  logic            int_req,
  output logic [PC_W-1:0] pc_write_data,
  output logic [1:0]      no_change,
  output logic            fetch_nop_LD,
  output logic            reset_pc,
  output logic            Reset_2Power5,
  output logic            flush_fd,
  output logic [PC_W-1:0] int_ret_pc,
  output logic            int_ack
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  pc_state_t       state;
  logic            int_go_c;
  logic            cnt_load_c;
  logic            cnt_dec_c;
  logic            cnt_zero_c;
  logic            cnt_one_c;
  logic [CNT_W-1:0] cnt;
  logic [PC_W-1:0] pc_seq_c;

  // Interrupt eligibility, sequential next PC and drain counter controls.
  always_comb begin
    int_go_c   = int_req && (hazard_hold == NO_CHANGE_NONE) && !load_use;
    pc_seq_c   = pc_cur + (is_32bit ? PC_W'(2) : PC_W'(1));
    cnt_load_c = (state == S_RUN) && int_go_c;
    cnt_dec_c  = (state == S_INT_DRAIN) && !cnt_zero_c;
  end

  pc_drain_counter #(
    .W(CNT_W)
  ) u_drain_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_c),
    .dec      (cnt_dec_c),
    .load_val (CNT_W'(DRAIN_CYCLES)),
    .count    (cnt),
    .zero_c   (cnt_zero_c),
    .one_c    (cnt_one_c)
  );

  // Sequencer state and registered PC-write controls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_RST;
      pc_write_data <= '0;
      no_change     <= NO_CHANGE_NONE;
      fetch_nop_LD  <= 1'b0;
      reset_pc      <= 1'b1;
      Reset_2Power5 <= 1'b0;
      flush_fd      <= 1'b0;
      int_ret_pc    <= '0;
      int_ack       <= 1'b0;
    end else begin
      pc_write_data <= pc_seq_c;
      no_change     <= NO_CHANGE_NONE;
      fetch_nop_LD  <= 1'b0;
      reset_pc      <= 1'b0;
      Reset_2Power5 <= 1'b0;
      flush_fd      <= 1'b0;
      int_ack       <= 1'b0;
      unique case (state)
        S_RST: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (int_go_c) begin
            int_ret_pc    <= pc_cur;
            no_change     <= NO_CHANGE_HOLD;
            pc_write_data <= pc_cur;
            state         <= S_INT_DRAIN;
          end else if (ret_valid) begin
            pc_write_data <= ret_addr;
            flush_fd      <= 1'b1;
          end else if (branch_taken) begin
            pc_write_data <= branch_target;
            flush_fd      <= 1'b1;
          end else if (hazard_hold != NO_CHANGE_NONE) begin
            no_change     <= hazard_hold;
            pc_write_data <= pc_cur;
          end else if (load_use) begin
            fetch_nop_LD  <= 1'b1;
            pc_write_data <= pc_cur;
          end
        end
        S_INT_DRAIN: begin
          no_change     <= NO_CHANGE_HOLD;
          flush_fd      <= 1'b1;
          pc_write_data <= pc_cur;
          // A redirect resolving during the drain becomes the resume point.
          if (ret_valid) begin
            int_ret_pc <= ret_addr;
          end else if (branch_taken) begin
            int_ret_pc <= branch_target;
          end
          if (cnt_one_c || cnt_zero_c) begin
            state <= S_INT_VEC;
          end
        end
        S_INT_VEC: begin
          Reset_2Power5 <= 1'b1;
          int_ack       <= 1'b1;
          pc_write_data <= VEC_ADDR;
          state         <= S_RUN;
        end
        default: begin
          state <= S_RST;
        end
      endcase
    end
  end

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic        is_32bit;
  logic [1:0]  hazard_hold;
  logic        load_use;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ret_valid;
  logic [31:0] ret_addr;
  logic        int_req;
  logic [31:0] pc_write_data;
  logic [1:0]  no_change;
  logic        fetch_nop_LD;
  logic        reset_pc;
  logic        Reset_2Power5;
  logic        flush_fd;
  logic [31:0] int_ret_pc;
  logic        int_ack;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(
    .DRAIN_CYCLES(3),
    .VEC_ADDR    (32'h20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_cur       (pc_cur),
    .is_32bit     (is_32bit),
    .hazard_hold  (hazard_hold),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .ret_valid    (ret_valid),
    .ret_addr     (ret_addr),
    .int_req      (int_req),
    .pc_write_data(pc_write_data),
    .no_change    (no_change),
    .fetch_nop_LD (fetch_nop_LD),
    .reset_pc     (reset_pc),
    .Reset_2Power5(Reset_2Power5),
    .flush_fd     (flush_fd),
    .int_ret_pc   (int_ret_pc),
    .int_ack      (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    is_32bit      = 1'b0;
    hazard_hold   = 2'b00;
    load_use      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    ret_valid     = 1'b0;
    ret_addr      = 32'h0;
    int_req       = 1'b0;
  endtask

  initial begin
    rst    = 1'b0;
    pc_cur = 32'h0;
    idle_inputs();

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_reset_pc", 32'(reset_pc), 32'd1);
      check("rst_pwd", pc_write_data, 32'h0);
      check("rst_no_change", 32'(no_change), 32'd0);
      check("rst_int_ret_pc", int_ret_pc, 32'h0);
      check("rst_int_ack", 32'(int_ack), 32'd0);
    end

    // Release: sequential increment from 0
    rst = 1'b1;
    tick();
    check("rel_reset_pc", 32'(reset_pc), 32'd0);
    check("rel_pwd", pc_write_data, 32'h1);
    tick();
    check("run0_pwd", pc_write_data, 32'h1);

    // Sequential fetch patterns
    pc_cur = 32'h10; is_32bit = 1'b1;
    tick();
    check("seq32_pwd", pc_write_data, 32'h12);
    check("seq32_flush", 32'(flush_fd), 32'd0);
    pc_cur = 32'hFFFF_FFFF; is_32bit = 1'b0;
    tick();
    check("seq_wrap_pwd", pc_write_data, 32'h0);

    // Branch overrides hold and load-use
    pc_cur = 32'h30; branch_taken = 1'b1; branch_target = 32'h40;
    hazard_hold = 2'b01; load_use = 1'b1;
    tick();
    check("conf_pwd", pc_write_data, 32'h40);
    check("conf_no_change", 32'(no_change), 32'd0);
    check("conf_nop", 32'(fetch_nop_LD), 32'd0);
    check("conf_flush", 32'(flush_fd), 32'd1);
    idle_inputs();
    pc_cur = 32'h40;
    tick();
    check("flush_pulse", 32'(flush_fd), 32'd0);
    check("after_br_pwd", pc_write_data, 32'h41);

    // Return beats branch
    ret_valid = 1'b1; ret_addr = 32'h80; branch_taken = 1'b1; branch_target = 32'h44;
    tick();
    check("ret_pwd", pc_write_data, 32'h80);
    check("ret_flush", 32'(flush_fd), 32'd1);
    idle_inputs();

    // Hazard hold passes its code through
    pc_cur = 32'h30; hazard_hold = 2'b10;
    tick();
    check("hold_no_change", 32'(no_change), 32'd2);
    check("hold_pwd", pc_write_data, 32'h30);
    hazard_hold = 2'b00; load_use = 1'b1;
    tick();
    check("lu_nop", 32'(fetch_nop_LD), 32'd1);
    check("lu_pwd", pc_write_data, 32'h30);
    check("lu_no_change", 32'(no_change), 32'd0);
    idle_inputs();

    // Interrupt entry and drain
    pc_cur = 32'h55; int_req = 1'b1;
    tick();
    check("int_entry_nc", 32'(no_change), 32'd1);
    check("int_ret_pc", int_ret_pc, 32'h55);
    check("int_entry_ack", 32'(int_ack), 32'd0);
    int_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin branch_taken = 1'b1; branch_target = 32'h99; end
      tick();
      branch_taken = 1'b0;
      check("drain_nc", 32'(no_change), 32'd1);
      check("drain_flush", 32'(flush_fd), 32'd1);
      check("drain_ack", 32'(int_ack), 32'd0);
      check("drain_vec", 32'(Reset_2Power5), 32'd0);
    end
    check("drain_redirect_ret_pc", int_ret_pc, 32'h99);
    tick();
    check("vec_force", 32'(Reset_2Power5), 32'd1);
    check("vec_ack", 32'(int_ack), 32'd1);
    check("vec_pwd", pc_write_data, 32'h20);
    check("vec_nc", 32'(no_change), 32'd0);
    pc_cur = 32'h20;
    tick();
    check("post_vec_ack", 32'(int_ack), 32'd0);
    check("post_vec_force", 32'(Reset_2Power5), 32'd0);
    check("post_vec_pwd", pc_write_data, 32'h21);

    // Interrupt blocked by load-use, taken next cycle
    pc_cur = 32'h60; int_req = 1'b1; load_use = 1'b1;
    tick();
    check("blk_nc", 32'(no_change), 32'd0);
    check("blk_nop", 32'(fetch_nop_LD), 32'd1);
    load_use = 1'b0;
    tick();
    check("blk_entry_nc", 32'(no_change), 32'd1);
    check("blk_ret_pc", int_ret_pc, 32'h60);
    int_req = 1'b0;
    tick(); tick(); tick();
    tick();
    check("blk_vec_ack", 32'(int_ack), 32'd1);

    // Reset during drain aborts the entry
    pc_cur = 32'h70; int_req = 1'b1;
    tick();
    check("abort_entry_ret_pc", int_ret_pc, 32'h70);
    int_req = 1'b0;
    tick();
    check("abort_drain_nc", 32'(no_change), 32'd1);
    rst = 1'b0;
    tick();
    check("abort_reset_pc", 32'(reset_pc), 32'd1);
    check("abort_ret_pc", int_ret_pc, 32'h0);
    check("abort_nc", 32'(no_change), 32'd0);
    check("abort_flush", 32'(flush_fd), 32'd0);
    rst = 1'b1;
    begin
      int acks = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (int_ack) acks++;
      end
      check("abort_no_ack", 32'(acks), 32'd0);
    end
    check("abort_run_ret_pc", int_ret_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pc_sequencer
